// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic PE family: drain FSM encoding and
// accumulator clamp limits.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SELF = 2'd1,
    FWD  = 2'd2
  } pe_state_e;

  // Largest representable accumulator value, right-aligned in 64 bits.
  // Assumes 2 <= acc_w <= 64.
  function automatic logic [63:0] sat_max(input int acc_w, input int is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed != 0) return ones >> (65 - acc_w);
    return ones >> (64 - acc_w);
  endfunction

  // Smallest representable accumulator value, as a right-aligned bit pattern.
  function automatic logic [63:0] sat_min(input int acc_w, input int is_signed);
    if (is_signed != 0) return 64'd1 << (acc_w - 1);
    return 64'd0;
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational MAC datapath: operand extension, multiply, accumulate,
// overflow detection and clamp/wrap. Assumes ACC_WIDTH >= 2*DATAWIDTH.
module pe_mac_sat
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ACC_WIDTH = 2*DATAWIDTH+4,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1
) (
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_b,
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic                 i_fire,
  input  logic                 i_clr,
  output logic [ACC_WIDTH-1:0] o_acc_next,
  output logic                 o_ovf
);

  localparam int PW = 2*DATAWIDTH;
  localparam int EW = ACC_WIDTH + 1;

  localparam logic [63:0] MAX64 = sat_max(ACC_WIDTH, SIGNED);
  localparam logic [63:0] MIN64 = sat_min(ACC_WIDTH, SIGNED);
  localparam logic [ACC_WIDTH-1:0] MAXV = MAX64[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] MINV = MIN64[ACC_WIDTH-1:0];

  logic        [PW-1:0]        w_prod_u;
  logic signed [PW-1:0]        w_prod_s;
  logic        [PW-1:0]        w_prod;
  logic        [EW-1:0]        w_prod_ext;
  logic        [ACC_WIDTH-1:0] w_base;
  logic        [EW-1:0]        w_base_ext;
  logic        [EW-1:0]        w_sum;
  logic                        w_over;
  logic        [ACC_WIDTH-1:0] w_sat;

  // Operands are widened to the product width before multiplying so no
  // product bits are lost in either signedness.
  assign w_prod_u = {{DATAWIDTH{1'b0}}, i_a} * {{DATAWIDTH{1'b0}}, i_b};
  assign w_prod_s = $signed({{DATAWIDTH{i_a[DATAWIDTH-1]}}, i_a}) *
                    $signed({{DATAWIDTH{i_b[DATAWIDTH-1]}}, i_b});

  // Extend, add with one guard bit, detect overflow, then clamp or wrap.
  always_comb begin
    w_prod     = (SIGNED != 0) ? w_prod_s : w_prod_u;
    w_prod_ext = (SIGNED != 0) ? {{(EW-PW){w_prod[PW-1]}}, w_prod}
                               : {{(EW-PW){1'b0}}, w_prod};
    // A clear happens before the accumulate.
    w_base     = i_clr ? '0 : i_acc;
    w_base_ext = (SIGNED != 0) ? {w_base[ACC_WIDTH-1], w_base} : {1'b0, w_base};
    w_sum      = w_base_ext + w_prod_ext;
    // Signed: guard bit disagrees with the result sign. Unsigned: carry out.
    w_over     = (SIGNED != 0) ? (w_sum[EW-1] ^ w_sum[EW-2]) : w_sum[EW-1];
    // Signed overflow direction follows the guard bit; unsigned only overflows upward.
    w_sat      = ((SIGNED != 0) && w_sum[EW-1]) ? MINV : MAXV;
    o_ovf      = i_fire & w_over;
    if (!i_fire)
      o_acc_next = w_base;
    else if (w_over && (SATURATE != 0))
      o_acc_next = w_sat;
    else
      o_acc_next = w_sum[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/pe_mac_stream.sv
// Output-stationary systolic PE: registered A/B pass-through, valid-qualified
// MAC with sticky overflow, and a double-buffered drain onto the column
// partial-sum chain (own word first, then everything from upstream).
module pe_mac_stream
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int ACC_WIDTH  = 2*DATAWIDTH+4,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 1,
  parameter int CHAIN_HEAD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] a_in,
  input  logic                 a_valid_in,
  input  logic [DATAWIDTH-1:0] b_in,
  input  logic                 b_valid_in,
  output logic [DATAWIDTH-1:0] a_out,
  output logic                 a_valid_out,
  output logic [DATAWIDTH-1:0] b_out,
  output logic                 b_valid_out,
  input  logic                 clear,
  input  logic                 drain,
  input  logic [ACC_WIDTH-1:0] psum_in,
  input  logic                 psum_valid_in,
  input  logic                 psum_last_in,
  output logic [ACC_WIDTH-1:0] psum_out,
  output logic                 psum_valid_out,
  output logic                 psum_last_out,
  output logic                 busy,
  output logic                 overflow
);

  localparam logic HEAD = (CHAIN_HEAD != 0);

  logic [DATAWIDTH-1:0] r_a;
  logic                 r_av;
  logic [DATAWIDTH-1:0] r_b;
  logic                 r_bv;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_dbuf;
  logic [ACC_WIDTH-1:0] r_psum;
  logic                 r_pv;
  logic                 r_pl;
  pe_state_e            r_state;
  pe_state_e            w_state_next;

  logic                 w_fire;
  logic                 w_drain_acc;
  logic                 w_clr;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_ovf_evt;

  assign w_fire      = a_valid_in & b_valid_in;
  assign w_drain_acc = drain & (r_state == IDLE);
  // A drain hands the accumulator to the drain buffer, so it restarts like a clear.
  assign w_clr       = clear | w_drain_acc;

  pe_mac_sat #(
    .DATAWIDTH (DATAWIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_mac (
    .i_a        (a_in),
    .i_b        (b_in),
    .i_acc      (r_acc),
    .i_fire     (w_fire),
    .i_clr      (w_clr),
    .o_acc_next (w_acc_next),
    .o_ovf      (w_ovf_evt)
  );

  // Operand pass-through: data loads only with its valid, valids always load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= '0;
      r_av <= 1'b0;
      r_b  <= '0;
      r_bv <= 1'b0;
    end else begin
      r_av <= a_valid_in;
      r_bv <= b_valid_in;
      if (a_valid_in) r_a <= a_in;
      if (b_valid_in) r_b <= b_in;
    end
  end

  // Accumulator, sticky overflow flag and drain snapshot buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_dbuf <= '0;
    end else begin
      r_acc <= w_acc_next;
      r_ovf <= (w_clr ? 1'b0 : r_ovf) | w_ovf_evt;
      if (w_drain_acc) r_dbuf <= r_acc;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Drain FSM next state: own word, then forward upstream until its last word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (drain) w_state_next = SELF;
      SELF:    w_state_next = HEAD ? IDLE : FWD;
      FWD:     if (psum_valid_in && psum_last_in) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Partial-sum chain output register; the word holds while not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psum <= '0;
      r_pv   <= 1'b0;
      r_pl   <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      r_pl <= 1'b0;
      case (r_state)
        SELF: begin
          r_psum <= r_dbuf;
          r_pv   <= 1'b1;
          r_pl   <= HEAD;
        end
        FWD: begin
          if (psum_valid_in) r_psum <= psum_in;
          r_pv <= psum_valid_in;
          r_pl <= psum_valid_in & psum_last_in;
        end
        default: ;
      endcase
    end
  end

  assign a_out          = r_a;
  assign a_valid_out    = r_av;
  assign b_out          = r_b;
  assign b_valid_out    = r_bv;
  assign psum_out       = r_psum;
  assign psum_valid_out = r_pv;
  assign psum_last_out  = r_pl;
  assign busy           = (r_state != IDLE);
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: reset, valid gating, clear, overlapped
// drain, unsigned/signed saturation, wrap, and a three-PE drain column.
module tb_pe_mac_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main instance: default widths (8/20), unsigned, saturating, chain head.
  logic [7:0]  m_a = '0, m_b = '0, m_ao, m_bo;
  logic        m_av = 0, m_bv = 0, m_clr = 0, m_dr = 0;
  logic        m_avo, m_bvo, m_pv, m_pl, m_busy, m_ovf;
  logic [19:0] m_ps;

  pe_mac_stream #(.CHAIN_HEAD(1)) u_main (
    .clk(clk), .rst(rst),
    .a_in(m_a), .a_valid_in(m_av), .b_in(m_b), .b_valid_in(m_bv),
    .a_out(m_ao), .a_valid_out(m_avo), .b_out(m_bo), .b_valid_out(m_bvo),
    .clear(m_clr), .drain(m_dr),
    .psum_in(20'd0), .psum_valid_in(1'b0), .psum_last_in(1'b0),
    .psum_out(m_ps), .psum_valid_out(m_pv), .psum_last_out(m_pl),
    .busy(m_busy), .overflow(m_ovf)
  );

  // Signed saturating 8x8 into 16 bits.
  logic [7:0]  s_a = '0, s_b = '0, s_ao, s_bo;
  logic        s_v = 0, s_clr = 0, s_dr = 0;
  logic        s_avo, s_bvo, s_pv, s_pl, s_busy, s_ovf;
  logic [15:0] s_ps;

  pe_mac_stream #(.DATAWIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1), .CHAIN_HEAD(1)) u_ssat (
    .clk(clk), .rst(rst),
    .a_in(s_a), .a_valid_in(s_v), .b_in(s_b), .b_valid_in(s_v),
    .a_out(s_ao), .a_valid_out(s_avo), .b_out(s_bo), .b_valid_out(s_bvo),
    .clear(s_clr), .drain(s_dr),
    .psum_in(16'd0), .psum_valid_in(1'b0), .psum_last_in(1'b0),
    .psum_out(s_ps), .psum_valid_out(s_pv), .psum_last_out(s_pl),
    .busy(s_busy), .overflow(s_ovf)
  );

  // Unsigned wrapping 8x8 into 16 bits.
  logic [7:0]  w_a = '0, w_b = '0, w_ao, w_bo;
  logic        w_v = 0, w_dr = 0;
  logic        w_avo, w_bvo, w_pv, w_pl, w_busy, w_ovf;
  logic [15:0] w_ps;

  pe_mac_stream #(.DATAWIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0), .CHAIN_HEAD(1)) u_wrap (
    .clk(clk), .rst(rst),
    .a_in(w_a), .a_valid_in(w_v), .b_in(w_b), .b_valid_in(w_v),
    .a_out(w_ao), .a_valid_out(w_avo), .b_out(w_bo), .b_valid_out(w_bvo),
    .clear(1'b0), .drain(w_dr),
    .psum_in(16'd0), .psum_valid_in(1'b0), .psum_last_in(1'b0),
    .psum_out(w_ps), .psum_valid_out(w_pv), .psum_last_out(w_pl),
    .busy(w_busy), .overflow(w_ovf)
  );

  // Column of three: row 0 is the head (top), row 2 the bottom.
  logic [7:0]  c_a [3];
  logic [2:0]  c_v = '0, c_dr = '0;
  logic [7:0]  c_ao [3];
  logic [7:0]  c_bo [3];
  logic [2:0]  c_avo, c_bvo, c_pv, c_pl, c_busy, c_ovf;
  logic [19:0] c_ps [3];
  logic [19:0] c_pin [3];
  logic [2:0]  c_pvin, c_plin;

  assign c_pin[0] = '0;
  assign c_pin[1] = c_ps[0];
  assign c_pin[2] = c_ps[1];
  assign c_pvin   = {c_pv[1], c_pv[0], 1'b0};
  assign c_plin   = {c_pl[1], c_pl[0], 1'b0};

  for (genvar i = 0; i < 3; i++) begin : g_col
    pe_mac_stream #(.CHAIN_HEAD((i == 0) ? 1 : 0)) u_pe (
      .clk(clk), .rst(rst),
      .a_in(c_a[i]), .a_valid_in(c_v[i]), .b_in(8'd1), .b_valid_in(c_v[i]),
      .a_out(c_ao[i]), .a_valid_out(c_avo[i]), .b_out(c_bo[i]), .b_valid_out(c_bvo[i]),
      .clear(1'b0), .drain(c_dr[i]),
      .psum_in(c_pin[i]), .psum_valid_in(c_pvin[i]), .psum_last_in(c_plin[i]),
      .psum_out(c_ps[i]), .psum_valid_out(c_pv[i]), .psum_last_out(c_pl[i]),
      .busy(c_busy[i]), .overflow(c_ovf[i])
    );
  end

  // Words seen at the bottom of the column.
  logic [19:0] cw [4];
  logic        cl [4];
  int          cn = 0;

  task automatic sample_bottom();
    if (c_pv[2]) begin
      if (cn < 4) begin
        cw[cn] = c_ps[2];
        cl[cn] = c_pl[2];
      end
      cn++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) c_a[i] = '0;
    for (int i = 0; i < 4; i++) begin cw[i] = '0; cl[i] = 1'b0; end

    // Reset state
    #1 rst = 1'b0;
    tick();
    tick();
    chk("rst_psum",   m_ps, 0);
    chk("rst_pvalid", m_pv, 0);
    chk("rst_plast",  m_pl, 0);
    chk("rst_busy",   m_busy, 0);
    chk("rst_ovf",    m_ovf, 0);
    chk("rst_aout",   m_ao, 0);
    chk("rst_avout",  m_avo, 0);
    chk("rst_bvout",  m_bvo, 0);
    rst = 1'b1;
    tick();

    // Valid gating: 3*4 twice, then a=5 alone
    m_a = 8'd3; m_b = 8'd4; m_av = 1; m_bv = 1;
    tick();
    tick();
    chk("pt_aout",  m_ao, 3);
    chk("pt_bout",  m_bo, 4);
    chk("pt_avout", m_avo, 1);
    m_a = 8'd5; m_b = 8'd9; m_bv = 0;
    tick();
    chk("gate_aout",  m_ao, 5);
    chk("gate_bout",  m_bo, 4);
    chk("gate_bvout", m_bvo, 0);
    m_av = 0;
    tick();
    chk("gate_avout0", m_avo, 0);
    chk("gate_aout_hold", m_ao, 5);
    m_dr = 1;
    tick();
    chk("drain_busy", m_busy, 1);
    chk("drain_pv_self", m_pv, 0);
    m_dr = 0;
    tick();
    chk("gate_acc24", m_ps, 24);
    chk("gate_pvalid", m_pv, 1);
    chk("gate_plast_head", m_pl, 1);
    chk("head_idle", m_busy, 0);
    tick();
    chk("pv_drop", m_pv, 0);
    chk("psum_hold", m_ps, 24);

    // Overlapped drain: acc=100, drain with 2*3 firing; drain held into SELF
    m_a = 8'd10; m_b = 8'd10; m_av = 1; m_bv = 1;
    tick();
    m_a = 8'd2; m_b = 8'd3; m_dr = 1;
    tick();
    m_av = 0; m_bv = 0;
    tick();
    m_dr = 0;
    chk("ovl_psum100", m_ps, 100);
    chk("ovl_pvalid", m_pv, 1);
    tick();
    chk("ovl_single_emit", m_pv, 0);
    m_dr = 1;
    tick();
    m_dr = 0;
    tick();
    chk("ovl_acc6", m_ps, 6);

    // Clear with simultaneous fire: acc = product only
    m_a = 8'd4; m_b = 8'd4; m_av = 1; m_bv = 1;
    tick();
    m_clr = 1; m_a = 8'd2; m_b = 8'd5;
    tick();
    m_clr = 0; m_av = 0; m_bv = 0; m_dr = 1;
    tick();
    m_dr = 0;
    tick();
    chk("clr_fire_acc10", m_ps, 10);

    // Unsigned saturation at 2^20-1: 16 x 65025 fits, the 17th does not
    m_a = 8'd255; m_b = 8'd255; m_av = 1; m_bv = 1;
    repeat (16) tick();
    chk("usat_ovf_before", m_ovf, 0);
    tick();
    chk("usat_ovf", m_ovf, 1);
    m_av = 0; m_bv = 0;
    tick();
    chk("usat_ovf_sticky", m_ovf, 1);
    m_dr = 1;
    tick();
    m_dr = 0;
    chk("usat_ovf_drain_clr", m_ovf, 0);
    tick();
    chk("usat_acc_max", m_ps, 20'hFFFFF);

    // Signed saturation high: (-128)*(-128) x3
    s_a = 8'h80; s_b = 8'h80; s_v = 1;
    tick();
    chk("ssat_ovf_first", s_ovf, 0);
    tick();
    tick();
    chk("ssat_ovf", s_ovf, 1);
    s_v = 0; s_dr = 1;
    tick();
    s_dr = 0;
    tick();
    chk("ssat_max", s_ps, 16'h7FFF);
    chk("ssat_ovf_after_drain", s_ovf, 0);

    // Clear after saturation
    s_v = 1;
    repeat (3) tick();
    chk("ssat_ovf_again", s_ovf, 1);
    s_v = 0; s_clr = 1;
    tick();
    s_clr = 0;
    chk("ssat_clr_ovf", s_ovf, 0);
    s_dr = 1;
    tick();
    s_dr = 0;
    tick();
    chk("ssat_clr_acc", s_ps, 0);

    // Signed saturation low: 127*(-128) x3 = -48768 -> -32768
    s_a = 8'h7F; s_b = 8'h80; s_v = 1;
    tick();
    tick();
    chk("ssat_neg_ovf_before", s_ovf, 0);
    tick();
    chk("ssat_neg_ovf", s_ovf, 1);
    s_v = 0; s_dr = 1;
    tick();
    s_dr = 0;
    tick();
    chk("ssat_min", s_ps, 16'h8000);

    // Wrap: 255*255 x2 = 130050 -> 130050 - 65536 = 64514
    w_a = 8'd255; w_b = 8'd255; w_v = 1;
    tick();
    chk("wrap_ovf_before", w_ovf, 0);
    tick();
    chk("wrap_ovf", w_ovf, 1);
    w_v = 0; w_dr = 1;
    tick();
    w_dr = 0;
    tick();
    chk("wrap_acc", w_ps, 64514);

    // Reset while the bottom PE is forwarding
    c_a[2] = 8'd5; c_v = 3'b100;
    tick();
    c_v = 3'b000; c_dr = 3'b100;
    tick();
    c_dr = 3'b000;
    tick();
    chk("col_pre_psum5", c_ps[2], 5);
    tick();
    chk("col_fwd_busy", c_busy[2], 1);
    rst = 1'b0;
    #2;
    chk("rst_fwd_psum",  c_ps[2], 0);
    chk("rst_fwd_pv",    c_pv[2], 0);
    chk("rst_fwd_busy",  c_busy[2], 0);
    chk("rst_fwd_aout",  c_ao[2], 0);
    chk("rst_fwd_avout", c_avo[2], 0);
    tick();
    rst = 1'b1;
    tick();

    // Column drain skewed one cycle per row, bottom first: 7 (bottom), 8, 9 (head)
    c_a[0] = 8'd9; c_a[1] = 8'd8; c_a[2] = 8'd7; c_v = 3'b111;
    tick();
    c_v = 3'b000; c_dr = 3'b100;
    tick();
    c_dr = 3'b010;
    tick();
    sample_bottom();
    c_dr = 3'b001;
    tick();
    sample_bottom();
    c_dr = 3'b000;
    for (int k = 0; k < 8; k++) begin
      tick();
      sample_bottom();
    end
    chk("col_count", cn, 3);
    chk("col_w0", cw[0], 7);
    chk("col_w1", cw[1], 8);
    chk("col_w2", cw[2], 9);
    chk("col_last", {29'd0, cl[0], cl[1], cl[2]}, 3'b001);
    chk("col_busy_done", c_busy, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
